// File: rtl/ram_readback_checker_if.sv
// FPGA-side RAM read port bundle.
// The checker drives address/enable; the RAM returns data.
interface ram_readback_checker_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] fpga_addr;
   logic              fpga_ce;
   logic [DATA_W-1:0] fpga_rd_data;

   modport master (
      output fpga_addr,
      output fpga_ce,
      input  fpga_rd_data
   );

   modport slave (
      input  fpga_addr,
      input  fpga_ce,
      output fpga_rd_data
   );
endinterface

// File: rtl/ram_readback_checker.sv
// Reads back RAM words 0..WORD_COUNT-1 and checks each against
// its zero-extended address; reports pass/fail and error stats.
module ram_readback_checker #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 16,
   parameter int WORD_COUNT = 100,
   parameter int RD_LATENCY = 2,
   parameter int ERR_W      = 8
) (
   input  logic              fpga_clk,
   input  logic              fpga_rst,
   input  logic              start,
   input  logic              abort,
   ram_readback_checker_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              led_pass,
   output logic              led_fail
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORD_COUNT - 1);

   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_nxt;
   logic              ce_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              pass_nxt;
   logic [ERR_W-1:0]  err_nxt;
   logic [ERR_W-1:0]  err_inc;
   logic [ADDR_W-1:0] ferr_nxt;
   logic              seen;
   logic              seen_nxt;
   logic              flush;

   logic [RD_LATENCY-1:0] pipe_v;
   logic [ADDR_W-1:0]     pipe_a [RD_LATENCY];
   logic                  hit;
   logic                  tail_busy;

   // Tail compare, plus lookahead: will any tag still be in flight
   // after this edge?
   always_comb begin
      hit = pipe_v[RD_LATENCY-1] &&
            (bus.fpga_rd_data != DATA_W'(pipe_a[RD_LATENCY-1]));
      tail_busy = bus.fpga_ce;
      for (int i = 0; i < RD_LATENCY - 1; i++) begin
         tail_busy = tail_busy | pipe_v[i];
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nxt = state;
      addr_nxt  = bus.fpga_addr;
      ce_nxt    = bus.fpga_ce;
      busy_nxt  = busy;
      done_nxt  = done;
      pass_nxt  = pass;
      err_nxt   = err_count;
      ferr_nxt  = first_err_addr;
      seen_nxt  = seen;
      flush     = 1'b0;
      err_inc   = err_count;
      if (hit && (err_count != '1)) begin
         err_inc = err_count + 1'b1;
      end
      if (abort) begin
         state_nxt = IDLE;
         addr_nxt  = '0;
         ce_nxt    = 1'b0;
         busy_nxt  = 1'b0;
         done_nxt  = 1'b0;
         pass_nxt  = 1'b0;
         err_nxt   = '0;
         ferr_nxt  = '0;
         seen_nxt  = 1'b0;
         flush     = 1'b1;
      end else begin
         if (state == READ || state == DRAIN) begin
            err_nxt = err_inc;
            if (hit && !seen) begin
               ferr_nxt = pipe_a[RD_LATENCY-1];
               seen_nxt = 1'b1;
            end
         end
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state_nxt = READ;
                  addr_nxt  = '0;
                  ce_nxt    = 1'b1;
                  busy_nxt  = 1'b1;
                  done_nxt  = 1'b0;
                  pass_nxt  = 1'b0;
                  err_nxt   = '0;
                  ferr_nxt  = '0;
                  seen_nxt  = 1'b0;
               end
            end
            READ: begin
               if (bus.fpga_addr == LAST) begin
                  ce_nxt    = 1'b0;
                  state_nxt = DRAIN;
               end else begin
                  addr_nxt = bus.fpga_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (!tail_busy) begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = (err_inc == '0);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State and registered outputs.
   always_ff @(posedge fpga_clk) begin
      if (fpga_rst) begin
         state          <= IDLE;
         bus.fpga_addr  <= '0;
         bus.fpga_ce    <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
         seen           <= 1'b0;
         led_pass       <= 1'b1;
         led_fail       <= 1'b1;
      end else begin
         state          <= state_nxt;
         bus.fpga_addr  <= addr_nxt;
         bus.fpga_ce    <= ce_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         pass           <= pass_nxt;
         err_count      <= err_nxt;
         first_err_addr <= ferr_nxt;
         seen           <= seen_nxt;
         led_pass       <= !(done_nxt && pass_nxt);
         led_fail       <= !(done_nxt && !pass_nxt);
      end
   end

   // Read-tag pipeline tracking each issued address to its data.
   always_ff @(posedge fpga_clk) begin
      if (fpga_rst || flush) begin
         pipe_v <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_a[i] <= '0;
         end
      end else begin
         pipe_v[0] <= bus.fpga_ce;
         pipe_a[0] <= bus.fpga_addr;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
      end
   end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Bench for ram_readback_checker: two instances (default ERR_W and
// ERR_W=4) each reading its own latency-2 RAM model of one memory.
module tb_ram_readback_checker;

   localparam int AW = 7;
   localparam int DW = 16;
   localparam int WC = 100;
   localparam int RL = 2;

   typedef struct {
      int errs;
      int ferr;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;

   always #5 clk = ~clk;

   ram_readback_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus_m ();
   ram_readback_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus_s ();

   logic          busy_m, done_m, pass_m, lp_m, lf_m;
   logic [7:0]    err_m;
   logic [AW-1:0] ferr_m;
   logic          busy_s, done_s, pass_s, lp_s, lf_s;
   logic [3:0]    err_s;
   logic [AW-1:0] ferr_s;

   ram_readback_checker #(
      .ADDR_W(AW), .DATA_W(DW), .WORD_COUNT(WC),
      .RD_LATENCY(RL), .ERR_W(8)
   ) u_main (
      .fpga_clk(clk), .fpga_rst(rst), .start(start), .abort(abort),
      .bus(bus_m), .busy(busy_m), .done(done_m), .pass(pass_m),
      .err_count(err_m), .first_err_addr(ferr_m),
      .led_pass(lp_m), .led_fail(lf_m)
   );

   ram_readback_checker #(
      .ADDR_W(AW), .DATA_W(DW), .WORD_COUNT(WC),
      .RD_LATENCY(RL), .ERR_W(4)
   ) u_sat (
      .fpga_clk(clk), .fpga_rst(rst), .start(start), .abort(abort),
      .bus(bus_s), .busy(busy_s), .done(done_s), .pass(pass_s),
      .err_count(err_s), .first_err_addr(ferr_s),
      .led_pass(lp_s), .led_fail(lf_s)
   );

   logic [DW-1:0] mem [128];
   logic [DW-1:0] r1_m, r1_s;

   // Two-cycle read latency RAM models
   always @(posedge clk) begin
      r1_m <= mem[bus_m.fpga_addr];
      bus_m.fpga_rd_data <= r1_m;
      r1_s <= mem[bus_s.fpga_addr];
      bus_s.fpga_rd_data <= r1_s;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int addr_q[$];
   res_t res_q[$];

   // Read-address scoreboard
   always @(negedge clk) begin
      if (bus_m.fpga_ce === 1'b1) begin
         n_cmp++;
         if (addr_q.size() == 0) begin
            n_bad++;
            $display("FAIL rd_addr: got read of %0d, want no read",
                     bus_m.fpga_addr);
         end else begin
            int e;
            e = addr_q.pop_front();
            if (bus_m.fpga_addr !== AW'(e)) begin
               n_bad++;
               $display("FAIL rd_addr: got %0d, want %0d",
                        bus_m.fpga_addr, e);
            end
         end
      end
   end

   function automatic res_t model();
      res_t r;
      r.errs = 0;
      r.ferr = 0;
      for (int i = 0; i < WC; i++) begin
         if (mem[i] !== DW'(i)) begin
            if (r.errs == 0) r.ferr = i;
            r.errs++;
         end
      end
      return r;
   endfunction

   function automatic int cap(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   // mode 0: clean, 1: corrupt one address, 2: corrupt all
   task automatic set_mem(input int mode, input int bad);
      for (int i = 0; i < 128; i++) begin
         mem[i] = DW'(i);
         if (mode == 2) mem[i] = ~DW'(i);
      end
      if (mode == 1) mem[bad] = 16'h00FF;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < WC; i++) addr_q.push_back(i);
      res_q.push_back(model());
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int cyc);
      cyc = c0;
      while (done_m !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy_m, done_m, pass_m, lp_m, lf_m, bus_m.fpga_ce}
          !== 6'b000110) begin
         n_bad++;
         $display("FAIL reset_flags: got %b, want 000110",
                  {busy_m, done_m, pass_m, lp_m, lf_m, bus_m.fpga_ce});
      end
      n_cmp++;
      if ({err_m, ferr_m, bus_m.fpga_addr} !== '0) begin
         n_bad++;
         $display("FAIL reset_vals: got err=%0d ferr=%0d addr=%0d, want 0",
                  err_m, ferr_m, bus_m.fpga_addr);
      end
      rst = 1'b0;
   endtask

   task automatic test_pattern();
      int cyc;
      res_t r;
      set_mem(0, 0);
      pulse_start();
      wait_done(1, cyc);
      r = res_q.pop_front();
      n_cmp++;
      if (cyc != WC + RL + 1) begin
         n_bad++;
         $display("FAIL pat_done_cycle: got %0d, want %0d", cyc, WC+RL+1);
      end
      n_cmp++;
      if ({pass_m, lp_m, lf_m, busy_m} !== 4'b1010) begin
         n_bad++;
         $display("FAIL pat_flags: got %b, want 1010",
                  {pass_m, lp_m, lf_m, busy_m});
      end
      n_cmp++;
      if (err_m !== 8'(r.errs) || ferr_m !== AW'(r.ferr)) begin
         n_bad++;
         $display("FAIL pat_err: got %0d/%0d, want %0d/%0d",
                  err_m, ferr_m, r.errs, r.ferr);
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (done_m !== 1'b1 || bus_m.fpga_ce !== 1'b0) begin
         n_bad++;
         $display("FAIL pat_hold: got done=%b ce=%b, want 1 0",
                  done_m, bus_m.fpga_ce);
      end
   endtask

   task automatic test_single_error();
      int cyc;
      res_t r;
      set_mem(1, 37);
      pulse_start();
      wait_done(1, cyc);
      r = res_q.pop_front();
      n_cmp++;
      if (err_m !== 8'(r.errs) || ferr_m !== AW'(r.ferr)) begin
         n_bad++;
         $display("FAIL single_err: got %0d/%0d, want %0d/%0d",
                  err_m, ferr_m, r.errs, r.ferr);
      end
      n_cmp++;
      if ({pass_m, lp_m, lf_m} !== 3'b010) begin
         n_bad++;
         $display("FAIL single_flags: got %b, want 010",
                  {pass_m, lp_m, lf_m});
      end
   endtask

   task automatic test_restart();
      int cyc;
      res_t r;
      set_mem(0, 0);
      pulse_start();
      n_cmp++;
      if ({done_m, busy_m} !== 2'b01 || err_m !== 8'd0) begin
         n_bad++;
         $display("FAIL restart_clear: got done=%b busy=%b err=%0d, want 0 1 0",
                  done_m, busy_m, err_m);
      end
      wait_done(1, cyc);
      r = res_q.pop_front();
      n_cmp++;
      if (cyc != WC + RL + 1 || err_m !== 8'(r.errs) || pass_m !== 1'b1)
      begin
         n_bad++;
         $display("FAIL restart_result: got cyc=%0d err=%0d pass=%b, want %0d %0d 1",
                  cyc, err_m, pass_m, WC+RL+1, r.errs);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      res_t r;
      set_mem(2, 0);
      pulse_start();
      wait_done(1, cyc);
      r = res_q.pop_front();
      n_cmp++;
      if (err_s !== 4'(cap(r.errs, 15)) || ferr_s !== AW'(r.ferr)) begin
         n_bad++;
         $display("FAIL sat_err4: got %0d/%0d, want %0d/%0d",
                  err_s, ferr_s, cap(r.errs, 15), r.ferr);
      end
      n_cmp++;
      if (err_m !== 8'(cap(r.errs, 255))) begin
         n_bad++;
         $display("FAIL sat_err8: got %0d, want %0d",
                  err_m, cap(r.errs, 255));
      end
      n_cmp++;
      if ({pass_s, lf_s, done_s, pass_m} !== 4'b0010) begin
         n_bad++;
         $display("FAIL sat_flags: got %b, want 0010",
                  {pass_s, lf_s, done_s, pass_m});
      end
   endtask

   task automatic test_abort();
      int cyc;
      res_t r;
      set_mem(1, 5);
      pulse_start();
      repeat (49) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy_m, done_m, pass_m, lp_m, lf_m, bus_m.fpga_ce}
          !== 6'b000110) begin
         n_bad++;
         $display("FAIL abort_flags: got %b, want 000110",
                  {busy_m, done_m, pass_m, lp_m, lf_m, bus_m.fpga_ce});
      end
      n_cmp++;
      if (err_m !== 8'd0 || ferr_m !== '0 || err_s !== 4'd0) begin
         n_bad++;
         $display("FAIL abort_stats: got %0d/%0d/%0d, want 0/0/0",
                  err_m, ferr_m, err_s);
      end
      abort = 1'b0;
      addr_q.delete();
      r = res_q.pop_front();
      set_mem(0, 0);
      pulse_start();
      wait_done(1, cyc);
      r = res_q.pop_front();
      n_cmp++;
      if (cyc != WC + RL + 1 || pass_m !== 1'b1 || err_m !== 8'(r.errs))
      begin
         n_bad++;
         $display("FAIL abort_rerun: got cyc=%0d pass=%b err=%0d, want %0d 1 %0d",
                  cyc, pass_m, err_m, WC+RL+1, r.errs);
      end
   endtask

   task automatic test_extra_start();
      int cyc;
      res_t r;
      set_mem(1, 80);
      pulse_start();
      repeat (19) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(21, cyc);
      r = res_q.pop_front();
      n_cmp++;
      if (cyc != WC + RL + 1) begin
         n_bad++;
         $display("FAIL extra_cycle: got %0d, want %0d", cyc, WC+RL+1);
      end
      n_cmp++;
      if (err_m !== 8'(r.errs) || ferr_m !== AW'(r.ferr)) begin
         n_bad++;
         $display("FAIL extra_err: got %0d/%0d, want %0d/%0d",
                  err_m, ferr_m, r.errs, r.ferr);
      end
   endtask

   task automatic test_reset_drain();
      res_t r;
      set_mem(2, 0);
      pulse_start();
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy_m, done_m, pass_m, lp_m, lf_m, bus_m.fpga_ce}
          !== 6'b000110 || {err_m, ferr_m} !== '0) begin
         n_bad++;
         $display("FAIL rstdrain_vals: got %b err=%0d ferr=%0d, want 000110 0 0",
                  {busy_m, done_m, pass_m, lp_m, lf_m, bus_m.fpga_ce},
                  err_m, ferr_m);
      end
      rst = 1'b0;
      r = res_q.pop_front();
      repeat (5) @(negedge clk);
      n_cmp++;
      if (err_m !== 8'd0 || err_s !== 4'd0 || done_m !== 1'b0) begin
         n_bad++;
         $display("FAIL rstdrain_late: got err=%0d/%0d done=%b, want 0 0 0",
                  err_m, err_s, done_m);
      end
   endtask

   task automatic test_queues_empty();
      n_cmp++;
      if (addr_q.size() != 0 || res_q.size() != 0) begin
         n_bad++;
         $display("FAIL queues: got %0d/%0d left, want 0/0",
                  addr_q.size(), res_q.size());
      end
   endtask

   initial begin
      set_mem(0, 0);
      test_reset();
      test_pattern();
      test_single_error();
      test_restart();
      test_saturation();
      test_abort();
      test_extra_start();
      test_reset_drain();
      test_queues_empty();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_readback_checker.md
Name: ram_readback_checker

Overview:
- Downstream stage of the key-triggered FPGA-side RAM writer.
- After the writer finishes filling the shared dual-port RAM, this block reads back words 0..WORD_COUNT-1 on the FPGA port. It compares each word against the writer's pattern (zero-extended address) and reports pass/fail, error count and first failing address to LEDs and status outputs.
- Top level muxes the FPGA RAM port: this block owns it while busy=1.

Parameters:
ADDR_W, 7, RAM address width
DATA_W, 16, RAM data width
WORD_COUNT, 100, words checked (1..2^ADDR_W)
RD_LATENCY, 2, RAM read latency in cycles from ce/addr to valid fpga_rd_data (1..4)
ERR_W, 8, error counter width

Ports:
fpga_clk  in  1  clock
fpga_rst  in  1  reset; one clock; reset is synchronous and active-high
start  in  1  single-cycle pulse from writer write_done rising edge
abort  in  1  level; synchronised "RV writing" indication; forces idle
fpga_addr  out  ADDR_W  RAM read address
fpga_ce  out  1  RAM read enable
fpga_rd_data  in  DATA_W  RAM read data
busy  out  1  high from first read issue until done
done  out  1  check complete; held until next start or abort
pass  out  1  valid when done; 1 = zero errors
err_count  out  ERR_W  mismatches, saturating at all-ones
first_err_addr  out  ADDR_W  address of first mismatch; 0 if none
led_pass  out  1  active-low; 0 when done&&pass
led_fail  out  1  active-low; 0 when done&&!pass

Behaviour:
- Reset (sync, fpga_rst=1 at edge): state IDLE; fpga_addr=0, fpga_ce=0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, led_pass=1, led_fail=1; pipeline valid bits cleared. Reset mid-check abandons it with no partial results.
- All outputs registered.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE/DONE + start=1 (abort=0): clear err_count, first_err_addr, done, pass, LEDs, first-error flag; go READ.
- READ: fpga_ce=1, busy=1, fpga_addr increments 0..WORD_COUNT-1, one read per cycle. Cycle 1 after the start edge carries addr 0; cycle WORD_COUNT carries the last address. Then ce=0, go DRAIN.
- Tag pipeline: a shift register of RD_LATENCY stages carries {valid, addr}. At the edge ending cycle k+RD_LATENCY, fpga_rd_data is compared with the tag issued in cycle k.
- Expected word: {(DATA_W-ADDR_W) zeros, addr}.
- Mismatch handling:
  - err_count += 1, saturating; no wrap.
  - If this is the first mismatch, latch first_err_addr.
- DRAIN: wait until all pipeline valid bits are 0, then go DONE. Last compare occurs at the edge ending cycle WORD_COUNT+RD_LATENCY.
- DONE: done=1, busy=0, pass=(err_count==0), LEDs per port list. done rises in cycle WORD_COUNT+RD_LATENCY+1 after the start edge. State holds until start or abort.
- start while READ/DRAIN: ignored.
- start and abort in same cycle: abort wins.
- abort=1 in any state: next cycle IDLE; ce=0, busy=0, done=0, pass=0, LEDs off, pipeline flushed. err_count and first_err_addr are cleared.
- Saturation: err_count holds at 2^ERR_W-1 even if more mismatches follow; pass stays 0.
- Address width: fpga_addr never exceeds WORD_COUNT-1; no wrap.

Test Plan:
- Pattern match: start pulse with RAM model holding data=addr for 0..99 (RD_LATENCY=2). Required: ce high cycles 1..100, addr 0..99; done=1 in cycle 103; pass=1, err_count=0, led_pass=0, led_fail=1.
- Single error: corrupt addr 37 to 16'h00FF. Required: err_count=1, first_err_addr=37, pass=0, led_fail=0.
- Multiple errors and saturation: ERR_W=4, all words corrupted. Required: err_count=15, first_err_addr=0, pass=0.
- Abort mid-check: abort at cycle 50. Required: next cycle busy=0, ce=0, done=0, all status 0. A subsequent start with a clean RAM model gives a full pass.
- Ignored/restart start:
  - Extra start during READ does not change the address sequence.
  - start during DONE restarts: done=0 next cycle, and the fresh check completes with counters cleared.
- Sync reset during DRAIN: fpga_rst=1 for one edge. Required: all outputs at reset values the next cycle; no late compare updates err_count.
